// File: rtl/tx_frame_fetch_if.sv
// Bundle of RAM-read, serializer and control signals for tx_frame_fetch.
// master = fetch engine side, slave = RAM/serializer/controller side.
interface tx_frame_fetch_if #(
   parameter int A_WIDTH = 6
);
   logic               unread;
   logic [7:0]         rd_byte;
   logic [A_WIDTH+1:0] rd_addr;
   logic               rd_en;
   logic               rd_done;
   logic [7:0]         tx_data;
   logic               tx_valid;
   logic               tx_ready;
   logic               tx_last;
   logic               abort;
   logic               len_err;
   logic               busy;

   modport master (
      input  unread, rd_byte, tx_ready, abort,
      output rd_addr, rd_en, rd_done, tx_data, tx_valid, tx_last, len_err, busy
   );

   modport slave (
      output unread, rd_byte, tx_ready, abort,
      input  rd_addr, rd_en, rd_done, tx_data, tx_valid, tx_last, len_err, busy
   );
endinterface

// File: rtl/tx_frame_fetch.sv
// Streams one frame at a time out of a ping-pong RAM buffer to a byte serializer.
// Define TX_CRC_APPEND_EN to append a CRC-16/MODBUS trailer (low byte first).
module tx_frame_fetch #(
   parameter int A_WIDTH = 6
) (
   input  logic             clk,
   input  logic             reset,
   tx_frame_fetch_if.master bus
);
   localparam int          AW        = A_WIDTH + 2;
   localparam int unsigned BUF_BYTES = 2 ** AW;

   typedef enum logic [3:0] {
      IDLE,
      PEEK,
      PLEN,
      FETCH,
      LATCH,
      SEND,
`ifdef TX_CRC_APPEND_EN
      CRC_LO,
      CRC_HI,
`endif
      DONE
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic [7:0]    len_q, len_d;
   logic [8:0]    idx_q, idx_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          tx_valid_q, tx_valid_d;
   logic          tx_last_q, tx_last_d;
`ifdef TX_CRC_APPEND_EN
   logic [15:0]   crc_q, crc_d;
`endif

   logic       rd_strobe;
   logic       done_pulse;
   logic       len_err_pulse;
   logic       handshake;
   logic       len_bad;
   logic [8:0] last_idx;

   // A frame is 3 header bytes plus len payload bytes and must fit in one buffer.
   assign len_bad   = (32'd3 + 32'(bus.rd_byte)) > BUF_BYTES;
   assign last_idx  = {1'b0, len_q} + 9'd2;
   assign handshake = tx_valid_q && bus.tx_ready;

`ifdef TX_CRC_APPEND_EN
   function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
      logic [15:0] c;
      c = crc ^ {8'h00, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      end
      return c;
   endfunction
`endif

   always_comb begin
      state_d       = state_q;
      rd_addr_d     = rd_addr_q;
      len_d         = len_q;
      idx_d         = idx_q;
      tx_data_d     = tx_data_q;
      tx_valid_d    = tx_valid_q;
      tx_last_d     = tx_last_q;
`ifdef TX_CRC_APPEND_EN
      crc_d         = crc_q;
`endif
      rd_strobe     = 1'b0;
      done_pulse    = 1'b0;
      len_err_pulse = 1'b0;

      case (state_q)
         IDLE: begin
`ifdef TX_CRC_APPEND_EN
            crc_d = 16'hFFFF;
`endif
            if (bus.unread) begin
               state_d   = PEEK;
               rd_addr_d = AW'(2);
            end
         end

         PEEK: begin
            rd_strobe = 1'b1;
            state_d   = PLEN;
         end

         PLEN: begin
            len_d = bus.rd_byte;
            if (len_bad) begin
               len_err_pulse = 1'b1;
               done_pulse    = 1'b1;
               state_d       = IDLE;
            end else begin
               idx_d     = 9'd0;
               rd_addr_d = '0;
               state_d   = FETCH;
            end
         end

         FETCH: begin
            rd_strobe = 1'b1;
            state_d   = LATCH;
         end

         LATCH: begin
            tx_data_d  = bus.rd_byte;
            tx_valid_d = 1'b1;
`ifdef TX_CRC_APPEND_EN
            tx_last_d  = 1'b0;
`else
            tx_last_d  = (idx_q == last_idx);
`endif
            state_d    = SEND;
         end

         SEND: begin
            if (handshake) begin
`ifdef TX_CRC_APPEND_EN
               crc_d = crc16_byte(crc_q, tx_data_q);
`endif
               idx_d      = idx_q + 9'd1;
               tx_valid_d = 1'b0;
               tx_last_d  = 1'b0;
               if (idx_q < last_idx) begin
                  state_d   = FETCH;
                  rd_addr_d = AW'(idx_q + 9'd1);
               end else begin
`ifdef TX_CRC_APPEND_EN
                  state_d = CRC_LO;
`else
                  state_d = DONE;
`endif
               end
            end
         end

`ifdef TX_CRC_APPEND_EN
         // Each trailer byte spends one cycle loading, then waits for its handshake.
         CRC_LO: begin
            if (!tx_valid_q) begin
               tx_data_d  = crc_q[7:0];
               tx_valid_d = 1'b1;
               tx_last_d  = 1'b0;
            end else if (bus.tx_ready) begin
               tx_valid_d = 1'b0;
               state_d    = CRC_HI;
            end
         end

         CRC_HI: begin
            if (!tx_valid_q) begin
               tx_data_d  = crc_q[15:8];
               tx_valid_d = 1'b1;
               tx_last_d  = 1'b1;
            end else if (bus.tx_ready) begin
               tx_valid_d = 1'b0;
               tx_last_d  = 1'b0;
               state_d    = DONE;
            end
         end
`endif

         DONE: begin
            done_pulse = 1'b1;
            state_d    = IDLE;
         end

         default: state_d = IDLE;
      endcase

      // Abort keeps the buffer for a retry, so it must also suppress the release pulse.
      if (bus.abort && (state_q != IDLE)) begin
         state_d       = IDLE;
         tx_valid_d    = 1'b0;
         tx_last_d     = 1'b0;
         done_pulse    = 1'b0;
         len_err_pulse = 1'b0;
`ifdef TX_CRC_APPEND_EN
         crc_d         = 16'hFFFF;
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         rd_addr_q  <= '0;
         len_q      <= 8'd0;
         idx_q      <= 9'd0;
         tx_data_q  <= 8'd0;
         tx_valid_q <= 1'b0;
         tx_last_q  <= 1'b0;
`ifdef TX_CRC_APPEND_EN
         crc_q      <= 16'hFFFF;
`endif
      end else begin
         state_q    <= state_d;
         rd_addr_q  <= rd_addr_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         tx_last_q  <= tx_last_d;
`ifdef TX_CRC_APPEND_EN
         crc_q      <= crc_d;
`endif
      end
   end

   assign bus.rd_addr  = rd_addr_q;
   assign bus.rd_en    = rd_strobe;
   assign bus.rd_done  = done_pulse;
   assign bus.tx_data  = tx_data_q;
   assign bus.tx_valid = tx_valid_q;
   assign bus.tx_last  = tx_last_q;
   assign bus.len_err  = len_err_pulse;
   assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_tx_frame_fetch.sv
// Bench for tx_frame_fetch: RAM/serializer models plus a frame-level reference
// model of the transmitted byte stream (CRC trailer when TX_CRC_APPEND_EN is set).
module tb_tx_frame_fetch;
   localparam int AW    = 6;
   localparam int NSLOT = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   tx_frame_fetch_if #(.A_WIDTH(AW)) bus ();
   tx_frame_fetch #(.A_WIDTH(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

   logic [7:0] ram [NSLOT][256];
   int head = 0;
   int tail = 0;

   int total = 0;
   int bad   = 0;

   logic [8:0] obs_q [$];
   logic [8:0] exp_q [$];
   int done_cnt = 0, lerr_cnt = 0, in_frame = 0;
   int stall_viol = 0, fetch_viol = 0, pair_viol = 0;
   int done_exp = 0, lerr_exp = 0;
   int mode = 0;
   int abort_at = -1;
   logic abort_pending = 1'b0;

   // Buffer model: current frame is slot head; rd_done releases it.
   assign bus.unread = (head != tail);
   always @(posedge clk) begin
      if (bus.rd_en) bus.rd_byte <= ram[head % NSLOT][bus.rd_addr];
      if (bus.rd_done) head <= head + 1;
   end

   // Serializer-side monitor, sampled mid-cycle.
   logic       prev_stall = 1'b0;
   logic [8:0] prev_word  = '0;
   always @(negedge clk) begin
      if (reset) begin
         prev_stall = 1'b0;
         in_frame   = 0;
      end else begin
         if (prev_stall && !(bus.tx_valid && ({bus.tx_last, bus.tx_data} == prev_word)))
            stall_viol++;
         if (bus.tx_valid && bus.rd_en) fetch_viol++;
         if (bus.tx_valid && bus.tx_ready && !bus.abort) begin
            obs_q.push_back({bus.tx_last, bus.tx_data});
            in_frame++;
         end
         if (bus.abort && bus.busy) in_frame = 0;
         if (bus.rd_done) begin
            done_cnt++;
            in_frame = 0;
         end
         if (bus.len_err) begin
            lerr_cnt++;
            if (!bus.rd_done) pair_viol++;
         end
         prev_stall = bus.tx_valid && !bus.tx_ready && !bus.abort;
         prev_word  = {bus.tx_last, bus.tx_data};
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s: got=%0h want=%0h", tag, got, want);
      end
   endtask

   function automatic logic [15:0] model_crc(input int s);
      logic [15:0] c;
      c = 16'hFFFF;
      for (int k = 0; k < 3 + int'(ram[s][2]); k++) begin
         c = c ^ {8'h00, ram[s][k]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      end
      return c;
   endfunction

   // upto < 0: complete frame; otherwise only the first upto bytes (cut short).
   task automatic expect_frame(input int s, input int upto);
      int n;
      int m;
      logic last;
      logic [15:0] c;
      n = 3 + int'(ram[s][2]);
      m = (upto >= 0 && upto < n) ? upto : n;
      for (int k = 0; k < m; k++) begin
         last = 1'b0;
`ifndef TX_CRC_APPEND_EN
         if (upto < 0 && k == n - 1) last = 1'b1;
`endif
         exp_q.push_back({last, ram[s][k]});
      end
`ifdef TX_CRC_APPEND_EN
      if (upto < 0) begin
         c = model_crc(s);
         exp_q.push_back({1'b0, c[7:0]});
         exp_q.push_back({1'b1, c[15:8]});
      end
`endif
   endtask

   task automatic stage(input logic [7:0] len);
      int s;
      s = tail % NSLOT;
      for (int k = 0; k < 256; k++) ram[s][k] = 8'($urandom);
      ram[s][2] = len;
   endtask

   task automatic drive();
      if (abort_pending) begin
         chk("abort_to_idle", {31'd0, bus.busy}, 32'd0);
         abort_pending = 1'b0;
      end
      case (mode)
         0:       bus.tx_ready = 1'b1;
         1:       bus.tx_ready = !bus.tx_ready;
         default: bus.tx_ready = ($urandom_range(0, 3) != 0);
      endcase
      bus.abort = 1'b0;
      if (abort_at >= 0 && bus.tx_valid && bus.tx_ready && in_frame == abort_at) begin
         bus.abort     = 1'b1;
         abort_at      = -1;
         abort_pending = 1'b1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic run_until_idle(input string tag, input int budget);
      int n;
      n = 0;
      while ((head != tail || bus.busy) && n < budget) begin
         step();
         n++;
      end
      chk({tag, "_timeout"}, {31'd0, n >= budget}, 32'd0);
   endtask

   task automatic check_stream(input string tag);
      int m;
      chk({tag, "_len"}, 32'(obs_q.size()), 32'(exp_q.size()));
      m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < m; i++) chk($sformatf("%s_byte%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
      chk({tag, "_rd_done"}, 32'(done_cnt), 32'(done_exp));
      chk({tag, "_len_err"}, 32'(lerr_cnt), 32'(lerr_exp));
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int n;
      int s;
      int d0;
      bus.tx_ready = 1'b0;
      bus.abort    = 1'b0;
      reset        = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rd_en",    {31'd0, bus.rd_en},    32'd0);
      chk("rst_rd_done",  {31'd0, bus.rd_done},  32'd0);
      chk("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
      chk("rst_tx_last",  {31'd0, bus.tx_last},  32'd0);
      chk("rst_len_err",  {31'd0, bus.len_err},  32'd0);
      chk("rst_busy",     {31'd0, bus.busy},     32'd0);
      chk("rst_rd_addr",  32'(bus.rd_addr),      32'd0);
      chk("rst_tx_data",  32'(bus.tx_data),      32'd0);
      reset = 1'b0;
      step();

      // All-zero header frame, serializer always ready.
      mode = 0;
      s = tail % NSLOT;
      stage(8'd0);
      ram[s][0] = 8'h00;
      ram[s][1] = 8'h00;
      tail++;
      expect_frame(s, -1);
      done_exp++;
      step();
      chk("peek_rd_en",   {31'd0, bus.rd_en}, 32'd1);
      chk("peek_rd_addr", 32'(bus.rd_addr),   32'd2);
      chk("peek_busy",    {31'd0, bus.busy},  32'd1);
      run_until_idle("zero", 200);
      check_stream("zero");
      chk("zero_busy_end", {31'd0, bus.busy}, 32'd0);

      // 05 01 02 AA BB with the serializer stalling every other cycle.
      mode = 1;
      s = tail % NSLOT;
      stage(8'd2);
      ram[s][0] = 8'h05;
      ram[s][1] = 8'h01;
      ram[s][3] = 8'hAA;
      ram[s][4] = 8'hBB;
      tail++;
      expect_frame(s, -1);
      done_exp++;
      run_until_idle("toggle", 300);
      check_stream("toggle");

      // Lengths that do not fit: release buffer with len_err, send nothing.
      mode = 0;
      stage(8'hFE); tail++; done_exp++; lerr_exp++;
      stage(8'hFF); tail++; done_exp++; lerr_exp++;
      run_until_idle("lenerr", 100);
      check_stream("lenerr");
      chk("lenerr_tx_valid", {31'd0, bus.tx_valid}, 32'd0);

      // Largest frame that exactly fills the buffer.
      mode = 2;
      s = tail % NSLOT;
      stage(8'hFD); tail++;
      expect_frame(s, -1);
      done_exp++;
      run_until_idle("maxlen", 3000);
      check_stream("maxlen");

      // Abort during the handshake of byte idx=3; frame is retried from idx=0.
      mode = 0;
      s = tail % NSLOT;
      stage(8'd4); tail++;
      abort_at = 3;
      expect_frame(s, 3);
      expect_frame(s, -1);
      done_exp++;
      run_until_idle("abort", 300);
      check_stream("abort");
      chk("abort_fired", 32'(abort_at), 32'hFFFF_FFFF);

      // Reset while byte idx=5 waits in SEND.
      mode = 1;
      s = tail % NSLOT;
      stage(8'd8); tail++;
      n = 0;
      while (!(in_frame == 5 && bus.tx_valid) && n < 400) begin
         step();
         n++;
      end
      chk("reset_reach_idx5", {31'd0, n >= 400}, 32'd0);
      expect_frame(s, 5);
      expect_frame(s, -1);
      d0 = done_cnt;
      #2 reset = 1'b1;
      #1;
      chk("midrst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
      chk("midrst_busy",     {31'd0, bus.busy},     32'd0);
      chk("midrst_rd_en",    {31'd0, bus.rd_en},    32'd0);
      chk("midrst_rd_done",  {31'd0, bus.rd_done},  32'd0);
      chk("midrst_rd_addr",  32'(bus.rd_addr),      32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("midrst_no_done", 32'(done_cnt), 32'(d0));
      step();
      chk("repeek_rd_en",   {31'd0, bus.rd_en}, 32'd1);
      chk("repeek_rd_addr", 32'(bus.rd_addr),   32'd2);
      done_exp++;
      run_until_idle("midrst", 400);
      check_stream("midrst");

      // Two queued frames back-to-back.
      mode = 0;
      s = tail % NSLOT;
      stage(8'd0); tail++;
      expect_frame(s, -1);
      s = tail % NSLOT;
      stage(8'd2); tail++;
      expect_frame(s, -1);
      done_exp += 2;
      run_until_idle("pair", 300);
      check_stream("pair");

      // Random lengths and random serializer back-pressure.
      mode = 2;
      for (int r = 0; r < 6; r++) begin
         s = tail % NSLOT;
         stage(8'($urandom_range(0, 20)));
         tail++;
         expect_frame(s, -1);
         done_exp++;
      end
      run_until_idle("random", 4000);
      check_stream("random");

      chk("stall_stability", 32'(stall_viol), 32'd0);
      chk("no_valid_in_fetch", 32'(fetch_viol), 32'd0);
      chk("len_err_with_done", 32'(pair_viol), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
